// File: rtl/payload_engine_ctrl.sv
`default_nettype none
// ============================================================================
// payload_engine_ctrl : frames a byte stream into per-packet PCRE engine scans
// Revision 1.0
// ============================================================================
module payload_engine_ctrl #(
   parameter int NUM_ENG = 64,
   parameter int DRAIN   = 2,
   parameter int LEN_W   = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [7:0]         s_data,
   input  logic               s_valid,
   input  logic               s_sof,
   input  logic               s_eof,
   output logic               s_ready,
   output logic [7:0]         eng_byte,
   output logic               eng_en,
   output logic               eng_sod,
   input  logic [NUM_ENG-1:0] eng_match,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [NUM_ENG-1:0] m_match,
   output logic               m_any,
   output logic [LEN_W-1:0]   m_len,
   output logic               m_trunc
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_REPORT = 3'd4
   } state_t;

   localparam logic [3:0] c_drain_last = 4'(DRAIN - 1);

   state_t           r_state;
   logic [3:0]       r_drain_cnt;
   logic [LEN_W-1:0] r_len;
   logic             r_first;
   logic             r_trunc_pend;

   logic w_ready;
   logic w_accept;
   logic w_sof_break;

   // A new sof seen mid-packet closes the current packet without being consumed.
   always_comb begin
      w_ready     = 1'b0;
      w_sof_break = 1'b0;
      case (r_state)
         S_IDLE:   w_ready = s_valid & ~s_sof;
         S_STREAM: begin
            w_ready     = ~(s_sof & ~r_first);
            w_sof_break = s_valid & s_sof & ~r_first;
         end
         default:  w_ready = 1'b0;
      endcase
   end

   assign s_ready  = resetn & w_ready;
   assign w_accept = s_valid & s_ready & (r_state == S_STREAM);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         eng_sod      <= 1'b1;
         eng_en       <= 1'b0;
         eng_byte     <= 8'd0;
         m_valid      <= 1'b0;
         m_match      <= '0;
         m_any        <= 1'b0;
         m_len        <= '0;
         m_trunc      <= 1'b0;
         r_drain_cnt  <= 4'd0;
         r_len        <= '0;
         r_first      <= 1'b0;
         r_trunc_pend <= 1'b0;
      end else begin
         eng_en  <= w_accept;
         eng_sod <= 1'b0;
         if (w_accept) begin
            eng_byte <= s_data;
         end
         case (r_state)
            S_IDLE: begin
               if (s_valid && s_sof) begin
                  r_state <= S_CLEAR;
                  eng_sod <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_len   <= '0;
               r_first <= 1'b1;
               r_state <= S_STREAM;
            end
            S_STREAM: begin
               if (w_accept) begin
                  if (r_len != '1) begin
                     r_len <= r_len + 1'b1;
                  end
                  r_first <= 1'b0;
                  if (s_eof) begin
                     r_state      <= S_DRAIN;
                     r_trunc_pend <= 1'b0;
                     r_drain_cnt  <= 4'd0;
                  end
               end else if (w_sof_break) begin
                  r_state      <= S_DRAIN;
                  r_trunc_pend <= 1'b1;
                  r_drain_cnt  <= 4'd0;
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == c_drain_last) begin
                  m_match     <= eng_match;
                  m_any       <= |eng_match;
                  m_len       <= r_len;
                  m_trunc     <= r_trunc_pend;
                  m_valid     <= 1'b1;
                  r_drain_cnt <= 4'd0;
                  r_state     <= S_REPORT;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 4'd1;
               end
            end
            S_REPORT: begin
               // Going straight to CLEAR on a waiting sof saves the IDLE cycle.
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (s_valid && s_sof) begin
                     r_state <= S_CLEAR;
                     eng_sod <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
